// File: rtl/dm_access_ctrl_if.sv
// Bundles the request, response and data-memory signals of dm_access_ctrl.
// slave is the controller's view; master is the view of whoever surrounds it.
interface dm_access_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    logic [31:0]      mem_address;
    logic [31:0]      mem_data;
    logic             mem_rden;
    logic             mem_wren;
    logic [31:0]      mem_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_tag,
        input  resp_ready, mem_q,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err,
        output mem_address, mem_data, mem_rden, mem_wren
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_tag,
        output resp_ready, mem_q,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err,
        input  mem_address, mem_data, mem_rden, mem_wren
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// In-order load/store initiator for the 1-cycle-latency data memory.
// Optional out-of-range address checking is enabled by defining DM_ACCESS_ADDR_CHECK_EN.
module dm_access_ctrl #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int ADDR_W = 10
) (
    input  logic                       clock,
    input  logic                       rst,
    dm_access_ctrl_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic             weMem    [DEPTH];
    logic [31:0]      addrMem  [DEPTH];
    logic [31:0]      wdataMem [DEPTH];
    logic [TAG_W-1:0] tagMem   [DEPTH];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             respValid_q, respValid_d;
    logic [31:0]      respData_q, respData_d;
    logic [TAG_W-1:0] respTag_q, respTag_d;
    logic             respErr_q, respErr_d;
    logic [TAG_W-1:0] waitTag_q, waitTag_d;

    logic             push;
    logic             pop;
    logic             empty;
    logic             issueRd;
    logic             issueWr;
    logic             headWe;
    logic [31:0]      headAddr;
    logic [TAG_W-1:0] headTag;
    logic             addrBad;

    assign empty    = (count_q == '0);
    assign headWe   = weMem[rdPtr_q];
    assign headAddr = addrMem[rdPtr_q];
    assign headTag  = tagMem[rdPtr_q];

`ifdef DM_ACCESS_ADDR_CHECK_EN
    assign addrBad = |headAddr[31:ADDR_W];
`else
    logic unusedUpperAddr;
    assign unusedUpperAddr = |headAddr[31:ADDR_W];
    assign addrBad         = 1'b0;
`endif

    assign bus.req_ready   = (count_q < FULL_CNT);
    assign push            = bus.req_valid && bus.req_ready;
    assign pending         = count_q;

    assign bus.mem_address = {{(32-ADDR_W){1'b0}}, headAddr[ADDR_W-1:0]};
    assign bus.mem_data    = wdataMem[rdPtr_q];
    // Gating with rst keeps the DM quiet while held in reset, even with a stale head.
    assign bus.mem_rden    = issueRd && rst;
    assign bus.mem_wren    = issueWr && rst;

    assign bus.resp_valid  = respValid_q;
    assign bus.resp_data   = respData_q;
    assign bus.resp_tag    = respTag_q;
    assign bus.resp_err    = respErr_q;

    always_ff @(posedge clock) begin
        if (push) begin
            weMem[wrPtr_q]    <= bus.req_we;
            addrMem[wrPtr_q]  <= bus.req_addr;
            wdataMem[wrPtr_q] <= bus.req_wdata;
            tagMem[wrPtr_q]   <= bus.req_tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        issueRd     = 1'b0;
        issueWr     = 1'b0;
        respValid_d = respValid_q;
        respData_d  = respData_q;
        respTag_d   = respTag_q;
        respErr_d   = respErr_q;
        waitTag_d   = waitTag_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (headWe) begin
                        issueWr = !addrBad;
                    end else if (addrBad) begin
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                        respData_d  = '0;
                        respTag_d   = headTag;
                        state_d     = RESP;
                    end else begin
                        issueRd   = 1'b1;
                        waitTag_d = headTag;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                respValid_d = 1'b1;
                respData_d  = bus.mem_q;
                respTag_d   = waitTag_q;
                respErr_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    respValid_d = 1'b0;
                    respErr_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            respValid_q <= 1'b0;
            respData_q  <= '0;
            respTag_q   <= '0;
            respErr_q   <= 1'b0;
            waitTag_q   <= '0;
        end else begin
            state_q     <= state_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            respTag_q   <= respTag_d;
            respErr_q   <= respErr_d;
            waitTag_q   <= waitTag_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl with a behavioural 1-cycle-latency DM model.
// Expected load results are pushed at issue and popped by a monitor on each response handshake.
module tb_dm_access_ctrl;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst;
    logic [2:0] pending;

    dm_access_ctrl_if #(.TAG_W(TAG_W)) bus ();

    dm_access_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .ADDR_W(10)) dut (
        .clock   (clock),
        .rst     (rst),
        .bus     (bus),
        .pending (pending)
    );

    always #5 clock = ~clock;

    logic [31:0] dmMem [1024];
    exp_t        sbQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          rdenCount  = 0;
    int          wrenCount  = 0;

    // Behavioural DM: address and data captured at the edge, q valid for the following cycle.
    initial begin
        for (int i = 0; i < 1024; i++) dmMem[i] = 32'h0;
        dmMem[7]  = 32'd42;
        bus.mem_q = 32'h0;
    end

    always @(posedge clock) begin
        if (bus.mem_wren) dmMem[bus.mem_address[9:0]] <= bus.mem_data;
        if (bus.mem_rden) bus.mem_q <= dmMem[bus.mem_address[9:0]];
    end

    // Pulse counters let the bench confirm the exact number of DM accesses issued.
    always @(negedge clock) begin
        if (bus.mem_rden) rdenCount++;
        if (bus.mem_wren) wrenCount++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Response monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clock) begin
        if (rst && bus.resp_valid && bus.resp_ready) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_resp: got tag 0x%0h data 0x%0h expected no response",
                         bus.resp_tag, bus.resp_data);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("resp", {31'h0, bus.resp_err, bus.resp_tag, bus.resp_data},
                            {31'h0, e.err, e.tag, e.data});
            end
        end
    end

    // Caller must be aligned to a negedge; returns just after the accepting posedge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [TAG_W-1:0] tag);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_tag   = tag;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            checkOutput("push_timeout", 64'(bus.req_ready), 64'h1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1 bus.req_valid = 1'b0;
        end
    endtask

    task automatic loadReq(input logic [31:0] addr, input logic [TAG_W-1:0] tag,
                           input logic [31:0] expData, input logic expErr);
        exp_t e;
        e.data = expData;
        e.tag  = tag;
        e.err  = expErr;
        sbQ.push_back(e);
        applyStimulus(1'b0, addr, 32'h0, tag);
    endtask

    task automatic setReady(input logic v);
        @(posedge clock);
        #1 bus.resp_ready = v;
    endtask

    task automatic waitValid();
        int n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("resp_valid_timeout", 64'(bus.resp_valid), 64'h1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drain", 64'(sbQ.size()), 64'h0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wrenBefore;
        int rdenBefore;
        logic sawValid;

        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;

        @(negedge clock);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'h1);
        checkOutput("rst_pending", 64'(pending), 64'h0);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        checkOutput("rst_mem_en", 64'({bus.mem_rden, bus.mem_wren}), 64'h0);

        // Store then load to the same word.
        applyStimulus(1'b1, 32'd5, 32'hDEADBEEF, 5'd1);
        @(negedge clock);
        checkOutput("store_issue", {bus.mem_wren, bus.mem_rden, bus.mem_address[9:0], bus.mem_data},
                    {1'b1, 1'b0, 10'd5, 32'hDEADBEEF});
        loadReq(32'd5, 5'd2, 32'hDEADBEEF, 1'b0);
        @(negedge clock);
        checkOutput("load_issue", 64'({bus.mem_wren, bus.mem_rden, bus.mem_address[9:0]}),
                    64'({1'b0, 1'b1, 10'd5}));
        @(negedge clock);
        checkOutput("wait_no_valid", 64'({bus.resp_valid, bus.mem_rden}), 64'h0);
        waitDrain();

        // Response backpressure holds the result stable with no further DM reads.
        setReady(1'b0);
        @(negedge clock);
        loadReq(32'd7, 5'd4, 32'd42, 1'b0);
        @(negedge clock);
        waitValid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("hold_stable", {25'h0, bus.resp_valid, bus.mem_rden, bus.resp_tag, bus.resp_data},
                        {25'h0, 1'b1, 1'b0, 5'd4, 32'd42});
        end
        setReady(1'b1);
        @(negedge clock);
        waitDrain();

        // Fill the FIFO behind a load parked in RESP.
        setReady(1'b0);
        @(negedge clock);
        loadReq(32'd7, 5'd5, 32'd42, 1'b0);
        @(negedge clock);
        waitValid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            applyStimulus(1'b1, 32'd100 + 32'(i), 32'hA0 + 32'(i), 5'(i));
        end
        @(negedge clock);
        checkOutput("full_state", 64'({pending, bus.req_ready}), 64'({3'd4, 1'b0}));
        fork
            loadReq(32'd101, 5'd6, 32'hA1, 1'b0);
            begin
                repeat (3) @(negedge clock);
                checkOutput("full_blocked", 64'({pending, bus.req_ready}), 64'({3'd4, 1'b0}));
                setReady(1'b1);
            end
        join
        @(negedge clock);
        waitDrain();
        checkOutput("wren_pulses", 64'(wrenCount), 64'd5);

        // Reset during WAIT discards the outstanding read.
        @(negedge clock);
        applyStimulus(1'b0, 32'd5, 32'h0, 5'd7);
        @(negedge clock);
        checkOutput("mid_rden", 64'(bus.mem_rden), 64'h1);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("mid_rst_state", 64'({bus.resp_valid, pending}), 64'h0);
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus.resp_valid) sawValid = 1'b1;
        end
        checkOutput("mid_no_resp", 64'(sawValid), 64'h0);
        loadReq(32'd5, 5'd8, 32'hDEADBEEF, 1'b0);
        @(negedge clock);
        waitDrain();
        checkOutput("rden_pulses", 64'(rdenCount), 64'd6);

`ifdef DM_ACCESS_ADDR_CHECK_EN
        rdenBefore = rdenCount;
        loadReq(32'h400, 5'd3, 32'h0, 1'b1);
        @(negedge clock);
        waitDrain();
        checkOutput("oor_no_rden", 64'(rdenCount), 64'(rdenBefore));
        wrenBefore = wrenCount;
        applyStimulus(1'b1, 32'h800, 32'h12345678, 5'd9);
        repeat (4) @(negedge clock);
        checkOutput("oor_no_wren", 64'({wrenCount, 29'h0, pending}), 64'({wrenBefore, 32'h0}));
`else
        rdenBefore = rdenCount;
        wrenBefore = wrenCount;
        checkOutput("resp_err_tied", 64'(bus.resp_err), 64'h0);
`endif

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
